// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for mem_port_arbiter.
//   DEF_*     default parameter values for the arbiter
//   ID_W      requester id width (supports up to 4 requesters)
//   rdTag_t   per-stage read-return tag {valid, id}
//   lock_t    lock owner state {act, owner}, used when MEM_ARB_LOCK_EN is defined
//   nextIdx   round-robin successor of an index, modulo nreq
package mem_arb_pkg;
  localparam int DEF_NREQ   = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 1;
  localparam int ID_W       = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rdTag_t;

  typedef struct packed {
    logic            act;
    logic [ID_W-1:0] owner;
  } lock_t;

  function automatic logic [ID_W-1:0] nextIdx(input logic [ID_W-1:0] k, input int nreq);
    return (int'(k) == nreq - 1) ? '0 : k + 1'b1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker.
//   req  in   per-requester request
//   ptr  in   index with highest priority this cycle (0..NREQ-1)
//   gnt  out  one-hot grant (0 when no request)
//   idx  out  binary index of the granted requester (0 when no request)
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);
  logic found;
  int   cand;

  // Walk priority positions ptr, ptr+1, ... (wrapping); the inner loop maps
  // the rotated position back to a requester with constant indices only.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == cand)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = ID_W'(j);
        end
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port synchronous memory
// between NREQ requesters, with read data routed back after RD_LAT cycles.
//   clk, rst              clock; asynchronous active-high reset
//   req/req_we            per-requester request and write flag
//   req_addr/req_wdata    flattened per-requester address / write data
//   req_lock              (MEM_ARB_LOCK_EN only) keep ownership after this grant
//   gnt                   one-hot grant, same cycle as the memory command
//   rvalid/rdata          one-hot read return, rdata broadcast from mem_rdata
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro interface
//   idle                  no read in flight
// Optional feature macro: MEM_ARB_LOCK_EN (owner lock for atomic multi-byte
// fetches). Default build is plain round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]        req_lock,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   idle
);
  logic [NREQ-1:0][ADDR_W-1:0] addrArr;
  logic [NREQ-1:0][DATA_W-1:0] wdataArr;
  logic [NREQ-1:0]             pickReq;
  logic [NREQ-1:0]             gntRaw;
  logic [ID_W-1:0]             pickIdx;
  logic [ID_W-1:0]             ptr;
  logic                        anyGnt;
  logic                        selWe;
  logic [ADDR_W-1:0]           selAddr;
  logic [DATA_W-1:0]           selWdata;
  rdTag_t                      tagPipe [RD_LAT:1];

  for (genvar i = 0; i < NREQ; i++) begin : gUnpack
    assign addrArr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdataArr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_picker #(.NREQ(NREQ)) uPick (
    .req (pickReq),
    .ptr (ptr),
    .gnt (gntRaw),
    .idx (pickIdx)
  );

  // One-hot AND-OR mux: yields zeros on address/data when nothing is granted.
  always_comb begin
    selAddr  = '0;
    selWdata = '0;
    selWe    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gntRaw[i]) begin
        selAddr  = selAddr  | addrArr[i];
        selWdata = selWdata | wdataArr[i];
        selWe    = selWe    | req_we[i];
      end
    end
  end

  assign anyGnt    = |gntRaw;
  assign gnt       = rst ? '0 : gntRaw;
  assign mem_re    = ~rst & anyGnt & ~selWe;
  assign mem_we    = ~rst & anyGnt & selWe;
  assign mem_addr  = selAddr;
  assign mem_wdata = selWdata;
  assign rdata     = mem_rdata;

  // Read-return tag pipeline: stage 1 captures the grant, stage RD_LAT
  // lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= RD_LAT; s++) tagPipe[s] <= '0;
    end else begin
      tagPipe[1] <= '{valid: anyGnt & ~selWe, id: pickIdx};
      for (int s = 2; s <= RD_LAT; s++) tagPipe[s] <= tagPipe[s-1];
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++)
      if (tagPipe[RD_LAT].valid && (tagPipe[RD_LAT].id == ID_W'(i)))
        rvalid[i] = ~rst;
  end

  always_comb begin
    idle = 1'b1;
    for (int s = 1; s <= RD_LAT; s++)
      if (tagPipe[s].valid) idle = 1'b0;
  end

`ifdef MEM_ARB_LOCK_EN
  lock_t           lck;
  logic [NREQ-1:0] ownerOh;
  logic            lockSel;
  logic            ownerReq;
  logic            ownerGnt;

  // While locked only the owner is visible to the picker.
  always_comb begin
    ownerOh = '0;
    pickReq = '0;
    for (int i = 0; i < NREQ; i++) begin
      ownerOh[i] = (lck.owner == ID_W'(i));
      pickReq[i] = req[i] & (~lck.act | ownerOh[i]);
    end
  end

  assign lockSel  = |(gntRaw & req_lock);
  assign ownerReq = |(req & ownerOh);
  assign ownerGnt = |(gntRaw & ownerOh);

  // ptr only moves when no lock is taken or one is released, so a locked
  // burst never hands priority away mid-sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      lck <= '0;
    end else if (!lck.act) begin
      if (anyGnt) begin
        if (lockSel) lck <= '{act: 1'b1, owner: pickIdx};
        else         ptr <= nextIdx(pickIdx, NREQ);
      end
    end else if (!ownerReq || (ownerGnt && !lockSel)) begin
      lck.act <= 1'b0;
      ptr     <= nextIdx(lck.owner, NREQ);
    end
  end
`else
  assign pickReq = req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= '0;
    else if (anyGnt) ptr <= nextIdx(pickIdx, NREQ);
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench driving two arbiters (RD_LAT=1 and
// RD_LAT=3) from the same requesters, each with its own memory read pipe.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, reqWe, reqLock;
  logic [15:0] reqAddr, reqWdata;
  logic [1:0]  gnt1, rvalid1, gnt3, rvalid3;
  logic [7:0]  rdata1, memAddr1, memWdata1, memRdata1;
  logic [7:0]  rdata3, memAddr3, memWdata3, memRdata3;
  logic        memRe1, memWe1, idle1, memRe3, memWe3, idle3;

  typedef struct {
    int         due;
    logic [1:0] oh;
    logic [7:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   nVec = 0;
  int   nMis = 0;
  int   cyc  = 0;
  logic [7:0] shadow [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock(reqLock),
`endif
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .mem_re(memRe1), .mem_we(memWe1),
    .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_rdata(memRdata1), .idle(idle1)
  );

  mem_port_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock(reqLock),
`endif
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_re(memRe3), .mem_we(memWe3),
    .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_rdata(memRdata3), .idle(idle3)
  );

  // Memory model: unwritten locations return a fixed pattern.
  logic [7:0] mem [256];
  bit         wr  [256];
  logic [7:0] rp1;
  logic [7:0] rp3 [3];

  function automatic logic [7:0] initVal(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  function automatic logic [7:0] memRd(input logic [7:0] a);
    return wr[a] ? mem[a] : initVal(a);
  endfunction

  always @(posedge clk) begin
    if (memWe1) begin
      mem[memAddr1] <= memWdata1;
      wr[memAddr1]  <= 1'b1;
    end
    rp1    <= memRd(memAddr1);
    rp3[0] <= memRd(memAddr3);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign memRdata1 = rp1;
  assign memRdata3 = rp3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nVec++;
    if (obs !== want) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic expRead(input int id, input logic [7:0] data);
    q1.push_back('{due: cyc + 1, oh: 2'b01 << id, data: data});
    q3.push_back('{due: cyc + 3, oh: 2'b01 << id, data: data});
  endtask

  task automatic setReq(input int r, input logic on, input logic we, input logic [7:0] a,
                        input logic [7:0] d);
    req[r]           = on;
    reqWe[r]         = we;
    reqAddr[r*8 +: 8]  = a;
    reqWdata[r*8 +: 8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return monitors: any rvalid must match the head of the queue on its due cycle.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && (rvalid1 != 2'b00 || (q1.size() != 0 && q1[0].due <= cyc))) begin
      if (q1.size() == 0) chk("rv1_spurious", 32'(rvalid1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("rv1_oh",   32'(rvalid1), 32'(e.oh));
        chk("rv1_data", 32'(rdata1),  32'(e.data));
        chk("rv1_cyc",  32'(cyc),     32'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && (rvalid3 != 2'b00 || (q3.size() != 0 && q3[0].due <= cyc))) begin
      if (q3.size() == 0) chk("rv3_spurious", 32'(rvalid3), 32'd0);
      else begin
        e = q3.pop_front();
        chk("rv3_oh",   32'(rvalid3), 32'(e.oh));
        chk("rv3_data", 32'(rdata3),  32'(e.data));
        chk("rv3_cyc",  32'(cyc),     32'(e.due));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = initVal(8'(i));
    rst = 1'b1; req = 2'b11; reqWe = 2'b00; reqLock = 2'b00;
    reqAddr = 16'h1110; reqWdata = 16'h0000;

    // Outputs forced low during reset even with requests pending.
    @(negedge clk);
    chk("rst_gnt",   32'(gnt1),    32'd0);
    chk("rst_re",    32'(memRe1),  32'd0);
    chk("rst_we",    32'(memWe1),  32'd0);
    chk("rst_rv",    32'(rvalid1), 32'd0);
    chk("rst_idle",  32'(idle1),   32'd1);
    chk("rst_idle3", 32'(idle3),   32'd1);
    req = 2'b00;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("idle_gnt",  32'(gnt1),     32'd0);
    chk("idle_addr", 32'(memAddr1), 32'd0);

    // Single read
    step(); setReq(0, 1, 0, 8'h10, 8'h00);
    @(negedge clk);
    chk("rd_gnt",  32'(gnt1),     32'b01);
    chk("rd_re",   32'(memRe1),   32'd1);
    chk("rd_addr", 32'(memAddr1), 32'h10);
    chk("rd_idle", 32'(idle1),    32'd1);
    expRead(0, 8'hA5);
    step(); req = 2'b00;
    @(negedge clk) chk("rd_busy", 32'(idle1), 32'd0);
    step();
    @(negedge clk) chk("rd_idle_after", 32'(idle1), 32'd1);

    // Write from requester 1 (ptr is 1 after the grant to 0)
    step(); setReq(1, 1, 1, 8'h20, 8'h3C);
    @(negedge clk);
    chk("wr_gnt",   32'(gnt1),      32'b10);
    chk("wr_we",    32'(memWe1),    32'd1);
    chk("wr_re",    32'(memRe1),    32'd0);
    chk("wr_addr",  32'(memAddr1),  32'h20);
    chk("wr_wdata", 32'(memWdata1), 32'h3C);
    shadow[8'h20] = 8'h3C;
    step(); req = 2'b00;
    for (int i = 0; i < 3; i++) step();

    // Contention with ptr=0: grants alternate, every read returns in order
    setReq(0, 1, 0, 8'h10, 8'h00);
    setReq(1, 1, 0, 8'h11, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_gnt",  32'(gnt1), (k % 2 == 0) ? 32'b01 : 32'b10);
      chk("cont_gnt3", 32'(gnt3), (k % 2 == 0) ? 32'b01 : 32'b10);
      expRead(k % 2, shadow[(k % 2 == 0) ? 8'h10 : 8'h11]);
      step();
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) step();

    // Read back the written location (ptr=0 again)
    setReq(0, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    chk("rb_gnt", 32'(gnt1), 32'b01);
    expRead(0, 8'h3C);
    step(); req = 2'b00;
    for (int i = 0; i < 4; i++) step();

    // Reset while a read is in flight: no return afterwards, ptr back to 0
    setReq(0, 1, 0, 8'h11, 8'h00);
    @(negedge clk);
    chk("rr_gnt", 32'(gnt1), 32'b01);
    #1 rst = 1'b1;
    #1 chk("rr_gnt_forced", 32'(gnt1), 32'd0);
    step(); req = 2'b00;
    step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_rv1",   32'(rvalid1), 32'd0);
      chk("rr_rv3",   32'(rvalid3), 32'd0);
      chk("rr_idle3", 32'(idle3),   32'd1);
      step();
    end
    setReq(0, 1, 0, 8'h10, 8'h00);
    setReq(1, 1, 0, 8'h11, 8'h00);
    @(negedge clk);
    chk("rr_ptr0", 32'(gnt1), 32'b01);
    expRead(0, shadow[8'h10]);
    step(); req = 2'b00;
    for (int i = 0; i < 4; i++) step();

`ifdef MEM_ARB_LOCK_EN
    // Locked three-byte fetch by requester 0 while requester 1 waits
    rst = 1'b1; step(); rst = 1'b0;
    setReq(0, 1, 0, 8'h30, 8'h00);
    setReq(1, 1, 0, 8'h31, 8'h00);
    for (int k = 0; k < 4; k++) begin
      reqLock = (k < 2) ? 2'b01 : 2'b00;
      setReq(0, 1, 0, 8'(8'h30 + k), 8'h00);
      @(negedge clk);
      chk("lock_gnt", 32'(gnt1), (k < 3) ? 32'b01 : 32'b10);
      expRead((k < 3) ? 0 : 1, shadow[(k < 3) ? 8'(8'h30 + k) : 8'h31]);
      step();
    end
    req = 2'b00; reqLock = 2'b00;
    for (int i = 0; i < 4; i++) step();
`endif

    for (int i = 0; i < 4; i++) step();
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q3_empty", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
